// File: rtl/simon_enc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : simon_enc_ctrl
// Purpose  : Iterative SIMON32/64 block encryptor, one round per clock, with
//            on-the-fly key schedule and IDLE/RUN/DONE handshake control.
//            Optional macro SIMON_KEY_REUSE_EN adds a key shadow register and
//            a reuse_key port so a previously loaded key can be re-applied.
// Revision : 1.0 - initial release
// ============================================================================
module simon_enc_ctrl #(
    parameter int ROUNDS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] key_in,
    input  logic [31:0] pt_in,
`ifdef SIMON_KEY_REUSE_EN
    input  logic        reuse_key,
`endif
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic [31:0] ct_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // z0 sequence; element 0 is the leftmost bit of the published string
    localparam logic [0:61] c_z0 =
        62'b11111010001001010110000111001101111101000100101011000011100110;
    localparam logic [4:0]  c_rc_last = 5'(ROUNDS - 1);

    function automatic logic [15:0] rol1(input logic [15:0] v);
        return {v[14:0], v[15]};
    endfunction

    function automatic logic [15:0] rol2(input logic [15:0] v);
        return {v[13:0], v[15:14]};
    endfunction

    function automatic logic [15:0] rol8(input logic [15:0] v);
        return {v[7:0], v[15:8]};
    endfunction

    function automatic logic [15:0] ror1(input logic [15:0] v);
        return {v[0], v[15:1]};
    endfunction

    function automatic logic [15:0] ror3(input logic [15:0] v);
        return {v[2:0], v[15:3]};
    endfunction

    state_t      state_q, state_d;
    logic [15:0] x_q, x_d;
    logic [15:0] y_q, y_d;
    logic [15:0] kw0_q, kw0_d;
    logic [15:0] kw1_q, kw1_d;
    logic [15:0] kw2_q, kw2_d;
    logic [15:0] kw3_q, kw3_d;
    logic [4:0]  rc_q, rc_d;
    logic [31:0] ct_q, ct_d;

    logic [15:0] w_round_x;
    logic [15:0] w_t;
    logic [15:0] w_new;
    logic [63:0] w_key_src;

`ifdef SIMON_KEY_REUSE_EN
    logic [63:0] shadow_q, shadow_d;

    assign w_key_src = reuse_key ? shadow_q : key_in;
`else
    assign w_key_src = key_in;
`endif

    assign w_round_x = y_q ^ (rol1(x_q) & rol8(x_q)) ^ rol2(x_q) ^ kw0_q;
    assign w_t       = ror3(kw3_q) ^ kw1_q;
    assign w_new     = ~kw0_q ^ w_t ^ ror1(w_t) ^ 16'h0003
                     ^ {15'b0, c_z0[{1'b0, rc_q}]};

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        kw0_d   = kw0_q;
        kw1_d   = kw1_q;
        kw2_d   = kw2_q;
        kw3_d   = kw3_q;
        rc_d    = rc_q;
        ct_d    = ct_q;
`ifdef SIMON_KEY_REUSE_EN
        shadow_d = shadow_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    x_d     = pt_in[31:16];
                    y_d     = pt_in[15:0];
                    kw0_d   = w_key_src[15:0];
                    kw1_d   = w_key_src[31:16];
                    kw2_d   = w_key_src[47:32];
                    kw3_d   = w_key_src[63:48];
                    rc_d    = 5'd0;
`ifdef SIMON_KEY_REUSE_EN
                    if (!reuse_key) begin
                        shadow_d = key_in;
                    end
`endif
                end
            end
            S_RUN: begin
                x_d   = w_round_x;
                y_d   = x_q;
                kw0_d = kw1_q;
                kw1_d = kw2_q;
                kw2_d = kw3_q;
                kw3_d = w_new;
                rc_d  = rc_q + 5'd1;
                // ciphertext is captured from the final round's result, not the block register
                if (rc_q == c_rc_last) begin
                    state_d = S_DONE;
                    ct_d    = {w_round_x, x_q};
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            x_q     <= 16'd0;
            y_q     <= 16'd0;
            kw0_q   <= 16'd0;
            kw1_q   <= 16'd0;
            kw2_q   <= 16'd0;
            kw3_q   <= 16'd0;
            rc_q    <= 5'd0;
            ct_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            kw0_q   <= kw0_d;
            kw1_q   <= kw1_d;
            kw2_q   <= kw2_d;
            kw3_q   <= kw3_d;
            rc_q    <= rc_d;
            ct_q    <= ct_d;
        end
    end

`ifdef SIMON_KEY_REUSE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= 64'd0;
        end else begin
            shadow_q <= shadow_d;
        end
    end
`endif

    assign ready  = (state_q == S_IDLE);
    assign busy   = (state_q == S_RUN);
    assign done   = (state_q == S_DONE);
    assign ct_out = ct_q;

endmodule
`default_nettype wire

// File: tb/tb_simon_enc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_simon_enc_ctrl
// Purpose  : Scoreboard bench for simon_enc_ctrl against a reference SIMON32/64
//            model that expands the full key schedule up front.
// Revision : 1.0 - initial release
// ============================================================================
module tb_simon_enc_ctrl;

    localparam int          ROUNDS  = 32;
    localparam logic [63:0] KAT_KEY = 64'h1918111009080100;
    localparam logic [31:0] KAT_PT  = 32'h65656877;
    localparam logic [31:0] KAT_CT  = 32'hc69be9bb;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] key_in;
    logic [31:0] pt_in;
`ifdef SIMON_KEY_REUSE_EN
    logic        reuse_key;
`endif
    logic        ready;
    logic        busy;
    logic        done;
    logic [31:0] ct_out;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] exp_q[$];

    simon_enc_ctrl #(.ROUNDS(ROUNDS)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key_in   (key_in),
        .pt_in    (pt_in),
`ifdef SIMON_KEY_REUSE_EN
        .reuse_key(reuse_key),
`endif
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .ct_out   (ct_out)
    );

    always #5 clk = ~clk;

    // Reference: expand all round keys first, then run the Feistel rounds.
    function automatic logic [31:0] simon_ref(input logic [63:0] key, input logic [31:0] pt);
        logic [15:0] k [0:31];
        logic [61:0] z;
        logic [15:0] tmp, x, y;
        z = 62'b11111010001001010110000111001101111101000100101011000011100110;
        k[0] = key[15:0];
        k[1] = key[31:16];
        k[2] = key[47:32];
        k[3] = key[63:48];
        for (int i = 4; i < ROUNDS; i++) begin
            tmp  = {k[i-1][2:0], k[i-1][15:3]};
            tmp  = tmp ^ k[i-3];
            tmp  = tmp ^ {tmp[0], tmp[15:1]};
            k[i] = ~k[i-4] ^ tmp ^ {15'b0, z[6'(61 - (i - 4))]} ^ 16'h0003;
        end
        x = pt[31:16];
        y = pt[15:0];
        for (int i = 0; i < ROUNDS; i++) begin
            tmp = x;
            x   = y ^ ({x[14:0], x[15]} & {x[7:0], x[15:8]}) ^ {x[13:0], x[15:14]} ^ k[i];
            y   = tmp;
        end
        return {x, y};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [63:0] key, input logic [31:0] pt);
        start  = 1'b1;
        key_in = key;
        pt_in  = pt;
`ifdef SIMON_KEY_REUSE_EN
        reuse_key = 1'b0;
`endif
        tick();
        start = 1'b0;
        exp_q.push_back(simon_ref(key, pt));
    endtask

    // Edges counted from the accepting edge until done is seen.
    task automatic wait_done(output int cyc, output bit seen);
        cyc  = 0;
        seen = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (done === 1'b1) begin
                cyc  = i;
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        vectors++;
        if (ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready: got %b, expected 1", ready);
        end
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy_done: got busy=%b done=%b, expected 0 0", busy, done);
        end
        vectors++;
        if (ct_out !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_ct: got %h, expected 00000000", ct_out);
        end
    endtask

    task automatic test_kat;
        int          cyc;
        bit          seen;
        logic [31:0] exp;
        accept(KAT_KEY, KAT_PT);
        vectors++;
        if (busy !== 1'b1 || ready !== 1'b0) begin
            miscompares++;
            $display("FAIL kat_busy: got busy=%b ready=%b, expected 1 0", busy, ready);
        end
        wait_done(cyc, seen);
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL kat_timeout: got no done, expected done");
            exp_q.delete();
        end else begin
            // done occupies the cycle sampled by edge ROUNDS+1 after acceptance
            vectors++;
            if (cyc !== ROUNDS) begin
                miscompares++;
                $display("FAIL kat_latency: got %0d, expected %0d", cyc, ROUNDS);
            end
            exp = exp_q.pop_front();
            vectors++;
            if (ct_out !== exp || exp !== KAT_CT) begin
                miscompares++;
                $display("FAIL kat_ct: got %h, expected %h", ct_out, KAT_CT);
            end
        end
        tick();
        vectors++;
        if (done !== 1'b0 || ready !== 1'b1 || ct_out !== KAT_CT) begin
            miscompares++;
            $display("FAIL kat_idle_hold: got done=%b ready=%b ct=%h, expected 0 1 %h",
                     done, ready, ct_out, KAT_CT);
        end
    endtask

    task automatic test_random;
        int          cyc;
        bit          seen;
        logic [31:0] exp;
        logic [63:0] key;
        logic [31:0] pt;
        for (int n = 0; n < 3; n++) begin
            key = {$urandom, $urandom};
            pt  = $urandom;
            accept(key, pt);
            wait_done(cyc, seen);
            vectors++;
            if (!seen) begin
                miscompares++;
                $display("FAIL random_timeout[%0d]: got no done, expected done", n);
                exp_q.delete();
            end else begin
                exp = exp_q.pop_front();
                if (ct_out !== exp) begin
                    miscompares++;
                    $display("FAIL random_ct[%0d]: got %h, expected %h", n, ct_out, exp);
                end
            end
            repeat (3) tick();
            vectors++;
            if (ct_out !== exp) begin
                miscompares++;
                $display("FAIL random_hold[%0d]: got %h, expected %h", n, ct_out, exp);
            end
        end
    endtask

    task automatic test_ignored_start;
        int          dones = 0;
        logic [31:0] exp;
        accept(KAT_KEY, KAT_PT);
        repeat (4) tick();
        start = 1'b1;
        pt_in = 32'hdeadbeef;
        tick();
        start = 1'b0;
        repeat (14) tick();
        start  = 1'b1;
        pt_in  = 32'h12345678;
        key_in = 64'h0123456789abcdef;
        tick();
        start = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (done === 1'b1) begin
                dones++;
                if (exp_q.size() > 0) begin
                    exp = exp_q.pop_front();
                    vectors++;
                    if (ct_out !== exp) begin
                        miscompares++;
                        $display("FAIL ignored_ct: got %h, expected %h", ct_out, exp);
                    end
                end
            end
        end
        vectors++;
        if (dones !== 1) begin
            miscompares++;
            $display("FAIL ignored_done_count: got %0d, expected 1", dones);
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid;
        int dones = 0;
        accept(KAT_KEY, KAT_PT);
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        vectors++;
        if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || ct_out !== 32'd0) begin
            miscompares++;
            $display("FAIL midrst_state: got ready=%b busy=%b done=%b ct=%h, expected 1 0 0 00000000",
                     ready, busy, done, ct_out);
        end
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done === 1'b1) dones++;
        end
        vectors++;
        if (dones !== 0) begin
            miscompares++;
            $display("FAIL midrst_no_done: got %0d, expected 0", dones);
        end
        test_kat();
    endtask

    task automatic test_rst_priority;
        rst   = 1'b1;
        start = 1'b1;
        key_in = KAT_KEY;
        pt_in  = KAT_PT;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        vectors++;
        if (ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_priority: got ready=%b busy=%b, expected 1 0", ready, busy);
        end
        tick();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_priority_run: got busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_back_to_back;
        int          done_at[$];
        logic [31:0] exp;
        start  = 1'b1;
        key_in = KAT_KEY;
        pt_in  = KAT_PT;
`ifdef SIMON_KEY_REUSE_EN
        reuse_key = 1'b0;
`endif
        for (int i = 1; i <= 102; i++) begin
            if (ready === 1'b1) exp_q.push_back(simon_ref(KAT_KEY, KAT_PT));
            tick();
            if (done === 1'b1) begin
                done_at.push_back(i);
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL b2b_unexpected_done: got done at %0d, expected none", i);
                end else begin
                    exp = exp_q.pop_front();
                    if (ct_out !== exp) begin
                        miscompares++;
                        $display("FAIL b2b_ct: got %h, expected %h", ct_out, exp);
                    end
                end
            end
        end
        start = 1'b0;
        vectors++;
        if (done_at.size() !== 3) begin
            miscompares++;
            $display("FAIL b2b_done_count: got %0d, expected 3", done_at.size());
        end else begin
            for (int j = 1; j < 3; j++) begin
                vectors++;
                if (done_at[j] - done_at[j-1] !== ROUNDS + 2) begin
                    miscompares++;
                    $display("FAIL b2b_spacing[%0d]: got %0d, expected %0d",
                             j, done_at[j] - done_at[j-1], ROUNDS + 2);
                end
            end
        end
        exp_q.delete();
        tick();
    endtask

    task automatic test_input_hold;
        int          cyc;
        bit          seen;
        logic [31:0] exp;
        accept(KAT_KEY, KAT_PT);
        key_in = 64'd0;
        pt_in  = 32'd0;
        wait_done(cyc, seen);
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL hold_timeout: got no done, expected done");
            exp_q.delete();
        end else begin
            exp = exp_q.pop_front();
            if (ct_out !== exp) begin
                miscompares++;
                $display("FAIL hold_ct: got %h, expected %h", ct_out, exp);
            end
        end
        tick();
    endtask

`ifdef SIMON_KEY_REUSE_EN
    task automatic test_key_reuse;
        int cyc;
        bit seen;
        test_kat();
        start     = 1'b1;
        reuse_key = 1'b1;
        key_in    = 64'd0;
        pt_in     = KAT_PT;
        tick();
        start     = 1'b0;
        reuse_key = 1'b0;
        exp_q.push_back(simon_ref(KAT_KEY, KAT_PT));
        wait_done(cyc, seen);
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL reuse_timeout: got no done, expected done");
            exp_q.delete();
        end else if (ct_out !== exp_q.pop_front()) begin
            miscompares++;
            $display("FAIL reuse_ct: got %h, expected %h", ct_out, KAT_CT);
        end
        tick();
    endtask
`endif

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        key_in = 64'd0;
        pt_in  = 32'd0;
`ifdef SIMON_KEY_REUSE_EN
        reuse_key = 1'b0;
`endif
        test_reset();
        test_kat();
        test_random();
        test_ignored_start();
        test_reset_mid();
        test_rst_priority();
        test_back_to_back();
        test_input_hold();
`ifdef SIMON_KEY_REUSE_EN
        test_key_reuse();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion by time limit, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/simon_enc_ctrl.md
SIMON_ENC_CTRL -- requirements
Module: simon_enc_ctrl

Interface
REQ-001 SHALL have parameter ROUNDS, default 32, giving the number of SIMON32/64 rounds per block; legal range 1..32.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have port start, input, 1 bit: request to encrypt; sampled only while ready=1.
REQ-005 SHALL have port key_in, input, 64 bits: {k3,k2,k1,k0}; k0=key_in[15:0] is the round-0 key.
REQ-006 SHALL have port pt_in, input, 32 bits: plaintext {x,y}; x=pt_in[31:16].
REQ-007 SHALL have port ready, output, 1 bit: high only in IDLE.
REQ-008 SHALL have port busy, output, 1 bit: high only in RUN.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse, high only in DONE.
REQ-010 SHALL have port ct_out, output, 32 bits: ciphertext {x,y}; held from DONE until the next accepted start.

Function
REQ-011 SHALL implement FSM IDLE -> RUN on start&&ready; RUN -> DONE after ROUNDS RUN edges; DONE -> IDLE unconditionally.
REQ-012 SHALL, on the accepting edge, load block register from pt_in, key window kw0..kw3 from key_in, and clear round counter rc to 0.
REQ-013 SHALL apply exactly one round per RUN edge: x' = y ^ (rol1(x) & rol8(x)) ^ rol2(x) ^ kw0; y' = x; all operations mod 16 bits.
REQ-014 SHALL update the key window on each RUN edge: kw0<=kw1, kw1<=kw2, kw2<=kw3, kw3<=new.
REQ-015 SHALL compute new = ~kw0 ^ t ^ ror1(t) ^ 16'h0003 ^ {15'b0,z0[rc]}, where t = ror3(kw3) ^ kw1.
REQ-016 SHALL use z0 = 11111010001001010110000111001101111101000100101011000011100110, with z0[0] the leftmost bit.
REQ-017 SHALL increment rc on each RUN edge; the transition to DONE occurs on the edge where rc = ROUNDS-1.
REQ-018 SHALL assert done exactly ROUNDS+1 cycles after the accepting edge, with ct_out valid in the same cycle.
REQ-019 SHALL ignore start in RUN and DONE; no re-load and no queuing.
REQ-020 SHALL hold ct_out stable through IDLE; ct_out updates only on the RUN->DONE edge.
REQ-021 SHALL NOT let pt_in/key_in changes after the accepting edge affect the in-flight result.
REQ-022 SHALL accept a new start in the first IDLE cycle after DONE; back-to-back blocks are spaced ROUNDS+2 cycles apart.

Reset
REQ-023 SHALL, when rst=1 at a clock edge, force IDLE, rc=0, block/key registers=0, ct_out=0, done=0, busy=0, ready=1.
REQ-024 SHALL abort any in-flight block on reset, with no done pulse for it.
REQ-025 SHALL give rst priority over start on the same edge.

Configuration
REQ-026 SHALL, with macro SIMON_KEY_REUSE_EN defined, add port reuse_key (input, 1 bit) and a 64-bit shadow register loaded from key_in on every start accepted with reuse_key=0.
REQ-027 SHALL, with SIMON_KEY_REUSE_EN defined, load the key window from the shadow register (ignoring key_in) when start is accepted with reuse_key=1.
REQ-028 SHALL reset the shadow register to 0.
REQ-029 SHALL, without SIMON_KEY_REUSE_EN, omit the reuse_key port and shadow register, and always load the key window from key_in.

Verification
REQ-030 Known answer: ROUNDS=32, key_in=64'h1918111009080100, pt_in=32'h65656877 -> done 33 cycles after the accepting edge, ct_out=32'hc69be9bb.
REQ-031 Ignored start: pulse start at cycles 5 and 20 of RUN with different pt_in -> single done, ct_out=32'hc69be9bb.
REQ-032 Reset mid-operation: rst at RUN cycle 10 -> no done, ct_out=0, ready=1 on the next cycle; a re-run then yields c69be9bb.
REQ-033 Back-to-back: start held high continuously with the KAT inputs -> done pulses 34 cycles apart, each with c69be9bb.
REQ-034 Input hold: change key_in and pt_in to 0 one cycle after acceptance -> ct_out=32'hc69be9bb.
REQ-035 Key reuse (SIMON_KEY_REUSE_EN): KAT with reuse_key=0, then reuse_key=1 with key_in=0 and the same pt_in -> both give c69be9bb.
